// File: rtl/id_stage_pipe.sv
// Decode stage of the 5-stage MIPS core: instruction decode, operand
// forwarding, in-ID branch/jump resolution, interlock detection and the
// ID/EX pipeline register with saturating stall/flush event counters.
//
// Handshake: in_valid marks a real instruction in IF/ID. stall_o=1 tells the
// front end to hold PC and IF/ID, and this stage then loads a bubble into
// ID/EX. ex_stall_i=1 freezes ID/EX completely (and also raises stall_o).
// An instruction is consumed only in a cycle with in_valid=1 and stall_o=0.
// DATA_W must be wider than 16 (immediate sign extension).
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        pc_plus4,
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  rf_rdat1,
  input  logic [DATA_W-1:0]  rf_rdat2,
  input  logic               ex_we,
  input  logic               mem_we,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] ex_waddr,
  input  logic [RADDR_W-1:0] mem_waddr,
  input  logic [RADDR_W-1:0] wb_waddr,
  input  logic               ex_is_load,
  input  logic               mem_is_load,
  input  logic [DATA_W-1:0]  ex_res,
  input  logic [DATA_W-1:0]  mem_res,
  input  logic [DATA_W-1:0]  wb_res,
  input  logic               ex_stall_i,
  output logic               stall_o,
  output logic               if_flush_o,
  output logic               bj_taken_o,
  output logic [31:0]        bj_target_o,
  output logic               out_valid,
  output logic [7:0]         ctl_o,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [RADDR_W-1:0] rs_o,
  output logic [RADDR_W-1:0] rt_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam bit FWD = (FWD_EN != 0);

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic [RADDR_W-1:0] rs_f, rt_f, rd_f;
  logic [DATA_W-1:0]  imm_ext;

  logic [7:0] dec_ctl;
  logic       uses_rs, uses_rt;
  logic       is_beq, is_bne, is_j, is_br;

  logic rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;
  logic haz_rs, haz_rt;
  logic [DATA_W-1:0] op1_fwd, op2_fwd;
  logic [31:0] br_target, j_target;
  logic        resolve;

  assign opcode  = inst_i[31:26];
  assign funct   = inst_i[5:0];
  assign shamt   = inst_i[10:6];
  assign rs_f    = RADDR_W'(inst_i[25:21]);
  assign rt_f    = RADDR_W'(inst_i[20:16]);
  assign rd_f    = RADDR_W'(inst_i[15:11]);
  assign imm_ext = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};

  // Decode: ctl = {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl}; unknown -> NOP
  always_comb begin
    dec_ctl = 8'h00;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_R: begin
        // A nonzero shift amount on these ALU ops is a malformed word; treat as NOP.
        if (shamt == 5'd0) begin
          uses_rs = 1'b1;
          uses_rt = 1'b1;
          case (funct)
            FN_ADD:  dec_ctl = {5'b10001, ALU_ADD};
            FN_SUB:  dec_ctl = {5'b10001, ALU_SUB};
            FN_AND:  dec_ctl = {5'b10001, ALU_AND};
            FN_OR:   dec_ctl = {5'b10001, ALU_OR};
            FN_SLT:  dec_ctl = {5'b10001, ALU_SLT};
            default: begin
              uses_rs = 1'b0;
              uses_rt = 1'b0;
            end
          endcase
        end
      end
      OP_ADDI: begin dec_ctl = {5'b10010, ALU_ADD}; uses_rs = 1'b1; end
      OP_LW:   begin dec_ctl = {5'b11010, ALU_ADD}; uses_rs = 1'b1; end
      OP_SW:   begin dec_ctl = {5'b00110, ALU_ADD}; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:  begin dec_ctl = {5'b00000, ALU_SUB}; uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
      OP_BNE:  begin dec_ctl = {5'b00000, ALU_SUB}; uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; end
      OP_J:    begin is_j = 1'b1; end
      default: ;
    endcase
  end

  assign is_br = is_beq | is_bne;

  // Per-stage write matches; register 0 never matches anything.
  assign rs_ex  = ex_we  && (ex_waddr  == rs_f) && (rs_f != '0);
  assign rs_mem = mem_we && (mem_waddr == rs_f) && (rs_f != '0);
  assign rs_wb  = wb_we  && (wb_waddr  == rs_f) && (rs_f != '0);
  assign rt_ex  = ex_we  && (ex_waddr  == rt_f) && (rt_f != '0);
  assign rt_mem = mem_we && (mem_waddr == rt_f) && (rt_f != '0);
  assign rt_wb  = wb_we  && (wb_waddr  == rt_f) && (rt_f != '0);

  // Operand select: $0 -> 0, then youngest writer wins, regfile last.
  always_comb begin
    if (rs_f == '0)           op1_fwd = '0;
    else if (FWD && rs_ex)    op1_fwd = ex_res;
    else if (FWD && rs_mem)   op1_fwd = mem_res;
    else if (rs_wb)           op1_fwd = wb_res;
    else                      op1_fwd = rf_rdat1;
    if (rt_f == '0)           op2_fwd = '0;
    else if (FWD && rt_ex)    op2_fwd = ex_res;
    else if (FWD && rt_mem)   op2_fwd = mem_res;
    else if (rt_wb)           op2_fwd = wb_res;
    else                      op2_fwd = rf_rdat2;
  end

  // Interlocks: load data not ready, branch compare needs EX result now, or no EX/MEM bypass.
  assign haz_rs = uses_rs && ((rs_ex && ex_is_load) || (rs_mem && mem_is_load) ||
                              (is_br && rs_ex) || (!FWD && (rs_ex || rs_mem)));
  assign haz_rt = uses_rt && ((rt_ex && ex_is_load) || (rt_mem && mem_is_load) ||
                              (is_br && rt_ex) || (!FWD && (rt_ex || rt_mem)));
  assign stall_o = (in_valid && (haz_rs || haz_rt)) || ex_stall_i;

  // Redirect: only an instruction that actually leaves ID this cycle may redirect.
  assign resolve     = in_valid && !stall_o;
  assign br_target   = pc_plus4 + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
  assign j_target    = {pc_plus4[31:28], inst_i[25:0], 2'b00};
  assign bj_target_o = is_j ? j_target : br_target;
  assign bj_taken_o  = resolve && (is_j || (is_beq && (op1_fwd == op2_fwd)) ||
                                           (is_bne && (op1_fwd != op2_fwd)));
  assign if_flush_o  = bj_taken_o;

  // ID/EX register: freeze on EX back-pressure, bubble on interlock, else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctl_o     <= 8'h00;
      op1_o     <= '0;
      op2_o     <= '0;
      imm_o     <= '0;
      rs_o      <= '0;
      rt_o      <= '0;
      rd_o      <= '0;
    end else if (!ex_stall_i) begin
      if (stall_o) begin
        out_valid <= 1'b0;
        ctl_o     <= 8'h00;
      end else begin
        out_valid <= in_valid;
        ctl_o     <= in_valid ? dec_ctl : 8'h00;
        op1_o     <= op1_fwd;
        op2_o     <= op2_fwd;
        imm_o     <= imm_ext;
        rs_o      <= rs_f;
        rt_o      <= rt_f;
        rd_o      <= rd_f;
      end
    end
  end

  // Stall event counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                                  stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != '1))  stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

  // Flush event counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                                     flush_cnt_o <= '0;
    else if (if_flush_o && (flush_cnt_o != '1))  flush_cnt_o <= flush_cnt_o + CNT_W'(1);
  end

endmodule
